mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS main controller: the initiator that drives the datapath ALU (ALUOp, operand selects)
//  and consumes its Zero flag. Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and generates every
//  datapath write enable and mux select. ALU op codes use the `ALU_* macros in ctrl_encode_def.v.
// PARAMETERS
//  ILLEGAL_AS_NOP  1  1: undecodable instr pulses Illegal and returns to FETCH; 0: enter HALT until rst
// PORTS
//  clk       in   1  clock, all state on rising edge
//  rst       in   1  synchronous, active-high reset
//  Op        in   6  IR[31:26], stable from DECODE until instr end
//  Funct     in   6  IR[5:0]
//  Zero      in   1  ALU result==0, valid combinationally in EXEC
//  PCWrite   out  1  PC load enable
//  NPCOp     out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
//  IRWrite   out  1  IR load enable (memory read data -> IR)
//  MemWrite  out  1  data memory write enable
//  RegWrite  out  1  register file write enable
//  RegDst    out  2  write reg: 00 rt, 01 rd, 10 $31
//  WDSel     out  2  write data: 00 ALU out reg, 01 MDR, 10 PC (already PC+4)
//  EXTOp     out  1  1 sign-extend imm16, 0 zero-extend
//  ALUSrcA   out  1  0 rs data, 1 shamt (zero-extended IR[10:6])
//  ALUSrcB   out  1  0 rt data, 1 extended imm
//  ALUOp     out  4  `ALU_* code
//  InsDone   out  1  1-cycle pulse in final cycle of each instruction
//  Illegal   out  1  1-cycle pulse in DECODE for undecodable Op/Funct
//  Halted    out  1  high while in HALT
// BEHAVIOUR
//  State reg 3b: FETCH, DECODE, EXEC, MEM, WB, HALT. Only state is registered; outputs are
//  combinational from state, Op, Funct, Zero. Unlisted outputs are 0; ALUOp defaults `ALU_NOP.
//  rst high: next state FETCH; while rst high all enables/pulses forced 0, selects 0, ALUOp `ALU_NOP.
//  Reset mid-instruction abandons it: no write enable asserted in the rst cycle.
//  FETCH : IRWrite=1, PCWrite=1, NPCOp=00 -> DECODE.
//  DECODE: EXTOp per instr. j: PCWrite,NPCOp=10,InsDone -> FETCH. jal: additionally RegWrite,
//          RegDst=10, WDSel=10. jr (Op=0,Funct=001000): PCWrite,NPCOp=11,InsDone -> FETCH.
//          Illegal: Illegal=1, InsDone=1 -> FETCH (ILLEGAL_AS_NOP=1) or HALT (=0). Else -> EXEC.
//  EXEC  : R-type ALUSrcB=0; add ADD, sub SUB, and AND, or OR, xor XOR, nor NOR, slt SLT, sltu SLTU;
//          sll/srl/sra ALUSrcA=1 SLL/SRL/SRA; sllv/srlv/srav ALUSrcA=0. I-type ALUSrcB=1: addi ADD EXT=1,
//          andi AND EXT=0, ori OR EXT=0, slti SLT EXT=1, lui LUI, lw/sw ADD EXT=1 -> MEM.
//          beq/bne: ALUOp SUB, ALUSrcB=0, EXTOp=1, NPCOp=01, PCWrite=Zero (beq)/~Zero (bne), InsDone -> FETCH.
//          All other decoded ops -> WB.
//  MEM   : sw: MemWrite=1, InsDone -> FETCH. lw -> WB.
//  WB    : RegWrite=1, InsDone -> FETCH. R-type RegDst=01 WDSel=00; I-type RegDst=00 WDSel=00; lw WDSel=01.
//  HALT  : all enables 0, Halted=1; leaves only via rst.
//  Decode set: Op 000000 (Funct add 100000, sub 100010, and 100100, or 100101, xor 100110,
//  nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, sllv 000100,
//  srlv 000110, srav 000111, jr 001000), lw 100011, sw 101011, beq 000100, bne 000101, addi 001000,
//  andi 001100, ori 001101, slti 001010, lui 001111, j 000010, jal 000011. Anything else is illegal.
//  Cycles/instr: j/jal/jr/illegal 2, beq/bne 3, sw 4, R-type/I-ALU 4, lw 5. Zero only sampled in EXEC.
//  Exactly one InsDone per instruction; PCWrite never asserted twice within one instr except FETCH+branch/jump.
// TESTING
//  rst=1 for 2 cycles mid-lw (state MEM) -> all enables 0 during rst; FETCH with IRWrite=1 first cycle after.
//  Op=000000 Funct=100000 -> FETCH,DECODE,EXEC(ALUOp=`ALU_ADD),WB(RegWrite=1,RegDst=01); InsDone at cycle 4.
//  lw (100011) then sw (101011) -> lw 5 cycles with WDSel=01 in WB; sw MemWrite=1 in cycle 4, no RegWrite.
//  beq Zero=1 -> PCWrite=1,NPCOp=01 in EXEC; beq Zero=0 -> PCWrite=0; bne inverted; each 3 cycles.
//  sra Funct=000011 -> ALUSrcA=1,ALUOp=`ALU_SRA; jal -> DECODE PCWrite,RegWrite,RegDst=10,WDSel=10, 2 cycles.
//  Op=111111 -> Illegal pulse; ILLEGAL_AS_NOP=1 back to FETCH; =0 Halted=1 held 10 cycles, cleared by rst.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm - multi-cycle MIPS main controller
//
// Steps each instruction through FETCH / DECODE / EXEC / MEM / WB and drives
// every datapath write enable and mux select. Only the state is registered.
// All outputs are decoded combinationally from state, Op, Funct and Zero.
//
// Parameters
//   ILLEGAL_AS_NOP 1: an undecodable instruction pulses Illegal and returns
//                     to FETCH; 0: the controller parks in HALT until rst.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   Op, Funct      IR[31:26], IR[5:0]
//   Zero           ALU result == 0 (only looked at in EXEC)
//   PCWrite/NPCOp  PC load enable / next-PC select (00 +4, 01 br, 10 j, 11 rs)
//   IRWrite        IR load enable
//   MemWrite       data memory write enable
//   RegWrite       register file write enable
//   RegDst/WDSel   write register select / write data select
//   EXTOp          1 sign-extend imm16, 0 zero-extend
//   ALUSrcA/B      A: 0 rs, 1 shamt;  B: 0 rt, 1 extended imm
//   ALUOp          ALU operation code (ALU_* below)
//   InsDone        pulse in the last cycle of every instruction
//   Illegal        pulse in DECODE for an undecodable Op/Funct
//   Halted         high while in HALT
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic [1:0] NPCOp,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic       EXTOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       InsDone,
    output logic       Illegal,
    output logic       Halted
);

    // ALU operation codes shared with the datapath ALU
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    // ---------------- instruction decode ----------------
    logic       w_rtype;      // R-type ALU op (jr excluded)
    logic       w_shamt;      // sll/srl/sra take shamt on port A
    logic [3:0] w_r_alu;
    logic       w_jr, w_lw, w_sw, w_beq, w_bne, w_addi, w_andi, w_ori;
    logic       w_slti, w_lui, w_j, w_jal;
    logic       w_itype;      // immediate on port B in EXEC
    logic       w_sext;
    logic       w_legal;

    always_comb begin
        w_rtype = 1'b0;
        w_shamt = 1'b0;
        w_r_alu = ALU_NOP;
        if (Op == 6'b000000) begin
            w_rtype = 1'b1;
            case (Funct)
                6'b100000: w_r_alu = ALU_ADD;
                6'b100010: w_r_alu = ALU_SUB;
                6'b100100: w_r_alu = ALU_AND;
                6'b100101: w_r_alu = ALU_OR;
                6'b100110: w_r_alu = ALU_XOR;
                6'b100111: w_r_alu = ALU_NOR;
                6'b101010: w_r_alu = ALU_SLT;
                6'b101011: w_r_alu = ALU_SLTU;
                6'b000000: begin w_r_alu = ALU_SLL; w_shamt = 1'b1; end
                6'b000010: begin w_r_alu = ALU_SRL; w_shamt = 1'b1; end
                6'b000011: begin w_r_alu = ALU_SRA; w_shamt = 1'b1; end
                6'b000100: w_r_alu = ALU_SLL;
                6'b000110: w_r_alu = ALU_SRL;
                6'b000111: w_r_alu = ALU_SRA;
                default:   w_rtype = 1'b0;
            endcase
        end
    end

    assign w_jr    = (Op == 6'b000000) && (Funct == 6'b001000);
    assign w_lw    = (Op == 6'b100011);
    assign w_sw    = (Op == 6'b101011);
    assign w_beq   = (Op == 6'b000100);
    assign w_bne   = (Op == 6'b000101);
    assign w_addi  = (Op == 6'b001000);
    assign w_andi  = (Op == 6'b001100);
    assign w_ori   = (Op == 6'b001101);
    assign w_slti  = (Op == 6'b001010);
    assign w_lui   = (Op == 6'b001111);
    assign w_j     = (Op == 6'b000010);
    assign w_jal   = (Op == 6'b000011);
    assign w_itype = w_addi | w_andi | w_ori | w_slti | w_lui | w_lw | w_sw;
    assign w_sext  = w_addi | w_slti | w_lw | w_sw | w_beq | w_bne;
    assign w_legal = w_rtype | w_jr | w_itype | w_beq | w_bne | w_j | w_jal;

    // ---------------- outputs and next state ----------------
    always_comb begin
        PCWrite  = 1'b0;
        NPCOp    = 2'b00;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        WDSel    = 2'b00;
        EXTOp    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        ALUOp    = ALU_NOP;
        InsDone  = 1'b0;
        Illegal  = 1'b0;
        Halted   = 1'b0;
        w_next   = r_state;

        case (r_state)
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                EXTOp = w_sext;
                if (w_j || w_jal) begin
                    PCWrite = 1'b1;
                    NPCOp   = 2'b10;
                    InsDone = 1'b1;
                    w_next  = S_FETCH;
                    if (w_jal) begin
                        // link: PC already holds PC+4 after FETCH
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        WDSel    = 2'b10;
                    end
                end else if (w_jr) begin
                    PCWrite = 1'b1;
                    NPCOp   = 2'b11;
                    InsDone = 1'b1;
                    w_next  = S_FETCH;
                end else if (!w_legal) begin
                    Illegal = 1'b1;
                    InsDone = 1'b1;
                    w_next  = ILLEGAL_AS_NOP ? S_FETCH : S_HALT;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                EXTOp  = w_sext;
                w_next = S_WB;
                if (w_beq || w_bne) begin
                    ALUOp   = ALU_SUB;
                    NPCOp   = 2'b01;
                    PCWrite = w_beq ? Zero : ~Zero;
                    InsDone = 1'b1;
                    w_next  = S_FETCH;
                end else if (w_rtype) begin
                    ALUOp   = w_r_alu;
                    ALUSrcA = w_shamt;
                end else begin
                    ALUSrcB = 1'b1;
                    if (w_andi)      ALUOp = ALU_AND;
                    else if (w_ori)  ALUOp = ALU_OR;
                    else if (w_slti) ALUOp = ALU_SLT;
                    else if (w_lui)  ALUOp = ALU_LUI;
                    else             ALUOp = ALU_ADD;   // addi, lw, sw
                    if (w_lw || w_sw) w_next = S_MEM;
                end
            end
            S_MEM: begin
                if (w_sw) begin
                    MemWrite = 1'b1;
                    InsDone  = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                InsDone  = 1'b1;
                RegDst   = w_rtype ? 2'b01 : 2'b00;
                WDSel    = w_lw ? 2'b01 : 2'b00;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset abandons the current instruction: nothing may be written.
        if (rst) begin
            PCWrite  = 1'b0;
            NPCOp    = 2'b00;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 2'b00;
            WDSel    = 2'b00;
            EXTOp    = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 1'b0;
            ALUOp    = ALU_NOP;
            InsDone  = 1'b0;
            Illegal  = 1'b0;
            Halted   = 1'b0;
            w_next   = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm - directed bench for mc_ctrl_fsm
//
// Two controllers share all inputs: dut0 treats illegal instructions as NOPs,
// dut1 halts on them. Outputs are packed into a 20-bit vector
// {PCW,NPC[1:0],IRW,MW,RW,RD[1:0],WD[1:0],EXT,SA,SB,ALU[3:0],DONE,ILL,HLT}
// and compared per cycle against hand-written expected vectors.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    localparam logic [19:0] PCW    = 20'h80000;
    localparam logic [19:0] NPC_BR = 20'h20000;
    localparam logic [19:0] NPC_J  = 20'h40000;
    localparam logic [19:0] NPC_JR = 20'h60000;
    localparam logic [19:0] IRW    = 20'h10000;
    localparam logic [19:0] MW     = 20'h08000;
    localparam logic [19:0] RW     = 20'h04000;
    localparam logic [19:0] RD_RD  = 20'h01000;
    localparam logic [19:0] RD_31  = 20'h02000;
    localparam logic [19:0] WD_MDR = 20'h00400;
    localparam logic [19:0] WD_PC  = 20'h00800;
    localparam logic [19:0] EXT    = 20'h00200;
    localparam logic [19:0] SA     = 20'h00100;
    localparam logic [19:0] SB     = 20'h00080;
    localparam logic [19:0] DONE   = 20'h00004;
    localparam logic [19:0] ILL    = 20'h00002;
    localparam logic [19:0] HLT    = 20'h00001;
    localparam logic [19:0] FETCH  = PCW | IRW;

    localparam logic [3:0] A_ADD = 4'd1, A_SUB = 4'd2, A_OR = 4'd4, A_SRA = 4'd11;

    function automatic logic [19:0] alu(input logic [3:0] a);
        return {13'b0, a, 3'b0};
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero;

    logic       pcw0, irw0, mw0, rw0, ext0, sa0, sb0, done0, ill0, hlt0;
    logic [1:0] npc0, rd0, wd0;
    logic [3:0] alu0;
    logic       pcw1, irw1, mw1, rw1, ext1, sa1, sb1, done1, ill1, hlt1;
    logic [1:0] npc1, rd1, wd1;
    logic [3:0] alu1;
    logic [19:0] v0, v1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ILLEGAL_AS_NOP(1'b1)) dut0 (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(pcw0), .NPCOp(npc0), .IRWrite(irw0), .MemWrite(mw0),
        .RegWrite(rw0), .RegDst(rd0), .WDSel(wd0), .EXTOp(ext0),
        .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(alu0), .InsDone(done0),
        .Illegal(ill0), .Halted(hlt0)
    );

    mc_ctrl_fsm #(.ILLEGAL_AS_NOP(1'b0)) dut1 (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(pcw1), .NPCOp(npc1), .IRWrite(irw1), .MemWrite(mw1),
        .RegWrite(rw1), .RegDst(rd1), .WDSel(wd1), .EXTOp(ext1),
        .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(alu1), .InsDone(done1),
        .Illegal(ill1), .Halted(hlt1)
    );

    assign v0 = {pcw0, npc0, irw0, mw0, rw0, rd0, wd0, ext0, sa0, sb0, alu0, done0, ill0, hlt0};
    assign v1 = {pcw1, npc1, irw1, mw1, rw1, rd1, wd1, ext1, sa1, sb1, alu1, done1, ill1, hlt1};

    // Each task starts and ends at a falling edge with both controllers in FETCH.

    task automatic test_reset();
        rst = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        n_cmp++;
        if (v0 !== 20'h0 || v1 !== 20'h0) begin
            $display("FAIL reset_outputs got %h/%h want %h", v0, v1, 20'h0); n_bad++;
        end
        @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++;
        if (v0 !== FETCH || v1 !== FETCH) begin
            $display("FAIL reset_first_fetch got %h/%h want %h", v0, v1, FETCH); n_bad++;
        end
        @(negedge clk);
        // first instruction after the check above was a FETCH; finish it as j
        Op = 6'b000010; #1;
        n_cmp++;
        if (v0 !== (PCW | NPC_J | DONE) || v1 !== (PCW | NPC_J | DONE)) begin
            $display("FAIL reset_j_decode got %h/%h want %h", v0, v1, PCW | NPC_J | DONE); n_bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_lw();
        logic [19:0] e [6];
        logic        r [6];
        e = '{FETCH, EXT, SB | EXT | alu(A_ADD), 20'h0, 20'h0, FETCH};
        r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            Op = 6'b100011; Funct = 6'b0; Zero = 1'b0; rst = r[c]; #1;
            n_cmp++;
            if (v0 !== e[c] || v1 !== e[c]) begin
                $display("FAIL rst_mid_lw cyc%0d got %h/%h want %h", c, v0, v1, e[c]); n_bad++;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        // last row was a fresh FETCH; complete it as jr
        Op = 6'b000000; Funct = 6'b001000; #1;
        n_cmp++;
        if (v0 !== (PCW | NPC_JR | DONE) || v1 !== (PCW | NPC_JR | DONE)) begin
            $display("FAIL jr_decode got %h/%h want %h", v0, v1, PCW | NPC_JR | DONE); n_bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_rtype_add();
        logic [19:0] e [4];
        e = '{FETCH, 20'h0, alu(A_ADD), RW | RD_RD | DONE};
        for (int c = 0; c < 4; c++) begin
            Op = 6'b000000; Funct = 6'b100000; Zero = c[0]; #1;
            n_cmp++;
            if (v0 !== e[c] || v1 !== e[c]) begin
                $display("FAIL add cyc%0d got %h/%h want %h", c, v0, v1, e[c]); n_bad++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e [9];
        logic [5:0]  o [9];
        // lw: 5 cycles, then sw: 4 cycles
        e = '{FETCH, EXT, SB | EXT | alu(A_ADD), 20'h0, RW | WD_MDR | DONE,
              FETCH, EXT, SB | EXT | alu(A_ADD), MW | DONE};
        o = '{6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'b100011,
              6'b101011, 6'b101011, 6'b101011, 6'b101011};
        for (int c = 0; c < 9; c++) begin
            Op = o[c]; Funct = 6'b100000; Zero = 1'b1; #1;
            n_cmp++;
            if (v0 !== e[c] || v1 !== e[c]) begin
                $display("FAIL lw_sw cyc%0d got %h/%h want %h", c, v0, v1, e[c]); n_bad++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  o [4];
        logic        z [4];
        logic [19:0] x [4];
        o = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        z = '{1'b1, 1'b0, 1'b1, 1'b0};
        x = '{PCW, 20'h0, 20'h0, PCW};
        for (int i = 0; i < 4; i++) begin
            logic [19:0] e [3];
            e = '{FETCH, EXT, x[i] | NPC_BR | EXT | alu(A_SUB) | DONE};
            for (int c = 0; c < 3; c++) begin
                Op = o[i]; Funct = 6'b0; Zero = z[i]; #1;
                n_cmp++;
                if (v0 !== e[c] || v1 !== e[c]) begin
                    $display("FAIL branch%0d cyc%0d got %h/%h want %h", i, c, v0, v1, e[c]); n_bad++;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_misc_ops();
        logic [19:0] e [14];
        logic [5:0]  o [14];
        logic [5:0]  f [14];
        // sra (4), jal (2), addi (4), ori (4)
        e = '{FETCH, 20'h0, SA | alu(A_SRA), RW | RD_RD | DONE,
              FETCH, PCW | NPC_J | RW | RD_31 | WD_PC | DONE,
              FETCH, EXT, SB | EXT | alu(A_ADD), RW | DONE,
              FETCH, 20'h0, SB | alu(A_OR), RW | DONE};
        o = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h03, 6'h03, 6'h08, 6'h08, 6'h08, 6'h08,
              6'h0d, 6'h0d, 6'h0d, 6'h0d};
        f = '{6'h03, 6'h03, 6'h03, 6'h03, 6'h00, 6'h00, 6'h2a, 6'h2a, 6'h2a, 6'h2a,
              6'h08, 6'h08, 6'h08, 6'h08};
        for (int c = 0; c < 14; c++) begin
            Op = o[c]; Funct = f[c]; Zero = c[1]; #1;
            n_cmp++;
            if (v0 !== e[c] || v1 !== e[c]) begin
                $display("FAIL misc cyc%0d got %h/%h want %h", c, v0, v1, e[c]); n_bad++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_halt();
        Op = 6'b111111; Funct = 6'b0; Zero = 1'b0; #1;
        n_cmp++;
        if (v0 !== FETCH || v1 !== FETCH) begin
            $display("FAIL illegal_fetch got %h/%h want %h", v0, v1, FETCH); n_bad++;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (v0 !== (ILL | DONE) || v1 !== (ILL | DONE)) begin
            $display("FAIL illegal_decode got %h/%h want %h", v0, v1, ILL | DONE); n_bad++;
        end
        @(negedge clk);
        Op = 6'b000000; Funct = 6'b100000; #1;
        n_cmp++;
        if (v0 !== FETCH) begin
            $display("FAIL illegal_nop_refetch got %h want %h", v0, FETCH); n_bad++;
        end
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if (v1 !== HLT) begin
                $display("FAIL halt_hold cyc%0d got %h want %h", c, v1, HLT); n_bad++;
            end
            @(negedge clk);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if (v0 !== 20'h0 || v1 !== 20'h0) begin
            $display("FAIL halt_rst got %h/%h want %h", v0, v1, 20'h0); n_bad++;
        end
        @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++;
        if (v0 !== FETCH || v1 !== FETCH) begin
            $display("FAIL halt_release got %h/%h want %h", v0, v1, FETCH); n_bad++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_lw();
        test_rtype_add();
        test_back_to_back();
        test_branch();
        test_misc_ops();
        test_illegal_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
